// File: rtl/mp_add_sched.sv
// Round-robin scheduler sharing one 32-bit adder between two multi-precision add/sub requesters.
// Operands are processed one word per cycle, LSW first, with a registered carry between words.

module _32bit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module mp_add_sched #(
  parameter  int WORDS = 4,
  localparam int NW    = $clog2(WORDS),
  localparam int W     = 32 * WORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_sub,
  input  logic [NW-1:0] req0_nwords,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_sub,
  input  logic [NW-1:0] req1_nwords,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [W-1:0]  rsp_sum,
  output logic          rsp_carry,
  output logic          rsp_ovf,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic          last_q;
  logic          id_q;
  logic          sub_q;
  logic [NW-1:0] nw_q;
  logic [NW-1:0] k_q;
  logic          c_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic          ovf_q;

  logic          gnt_id;
  logic          accept;
  logic          last_word;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic [31:0]   add_s;
  logic          add_co;

  // Grant goes to the only valid requester, or to the one not served last.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) gnt_id = ~last_q;
    else if (req1_valid)          gnt_id = 1'b1;
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;

  assign last_word  = (k_q == nw_q);
  assign add_a      = a_q[{k_q, 5'd0} +: 32];
  assign add_b      = b_q[{k_q, 5'd0} +: 32] ^ {32{sub_q}};

  _32bit_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (c_q),
    .s    (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_word) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      sub_q   <= 1'b0;
      nw_q    <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= gnt_id ? req1_a : req0_a;
      b_q     <= gnt_id ? req1_b : req0_b;
      sub_q   <= gnt_id ? req1_sub : req0_sub;
      c_q     <= gnt_id ? req1_sub : req0_sub;
      nw_q    <= gnt_id ? req1_nwords : req0_nwords;
      id_q    <= gnt_id;
      last_q  <= gnt_id;
      k_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state == RUN) begin
      sum_q[{k_q, 5'd0} +: 32] <= add_s;
      c_q                      <= add_co;
      if (last_word) begin
        carry_q <= add_co;
        ovf_q   <= (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
      end else begin
        k_q <= k_q + NW'(1);
      end
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = (state != IDLE);

endmodule

// File: doc/mp_add_sched.md
Name: mp_add_sched

Overview:
- Round-robin scheduler that shares one `_32bit_adder` instance between two requesters.
- Each request is a multi-precision add or subtract of up to WORDS 32-bit words.
- Executes one word per cycle, least-significant word first, with a registered carry chained between words.
- Sits in the execute stage wherever wide arithmetic (64/128-bit) is needed without duplicating adders.

Parameters:
WORDS, 4, maximum operand length in 32-bit words (power of two, >=2); NW = log2(WORDS)

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_sub  input  1  1 = A-B, 0 = A+B
req0_nwords  input  NW  operand length minus one (0 = 1 word)
req0_a  input  32*WORDS  operand A, word 0 at [31:0]
req0_b  input  32*WORDS  operand B
req1_valid, req1_ready, req1_sub, req1_nwords, req1_a, req1_b  same as requester 0
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester that issued this result
rsp_sum  output  32*WORDS  result; words above nwords are zero
rsp_carry  output  1  final carry-out (for sub: 1 = no borrow)
rsp_ovf  output  1  two's-complement overflow of the top used word
busy  output  1  state != IDLE

Behaviour:
- rst_n low forces state IDLE, rr pointer last=1 (requester 0 wins first), and all result/operand registers to 0.
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, rsp_ovf=0, busy=0.
- req*_ready is combinational: high only in IDLE, for the granted requester, which must have valid=1.
- Reset mid-operation aborts the operation; no response is produced.
- FSM IDLE:
  - If exactly one valid, grant it.
  - If both valid, grant the requester != last.
  - On the grant/handshake: latch a, b, sub, nwords and id; set word index k=0; carry register c=sub; last=id; go to RUN.
  - Otherwise stay in IDLE.
- FSM RUN (one cycle per word):
  - Adder inputs: A=a[k], B = sub ? ~b[k] : b[k], carry_in=c.
  - Register S into sum[k] and carry_out into c.
  - On the final word (k==nwords): capture ovf = (A.msb==B.msb) & (S.msb!=A.msb) using the inverted B; rsp_carry=carry_out; go to DONE.
  - Otherwise k<=k+1.
- FSM DONE:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready go to IDLE; rsp_valid drops the next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- Latency: handshake in cycle T; RUN occupies T+1..T+nwords+1; rsp_valid first high in cycle T+nwords+2. The minimum issue interval is nwords+3 cycles.
- sum is cleared to 0 at accept, so unused upper words read 0. Operand bits above word nwords are ignored.
- Arbitration is fair: with both requesters continuously valid, grants alternate 0,1,0,1.
- A requester that drops valid before ready is simply not granted. Inputs are sampled only at the handshake; changes during RUN/DONE have no effect.
- Arithmetic is modulo 2^(32*(nwords+1)). Word arithmetic is done only through the shared `_32bit_adder` instance; no other adder is inferred.

Test Plan:
- Single add:
  - Stimulus: req0 nwords=1, a=0x00000000_FFFFFFFF, b=0x00000000_00000001.
  - Response: rsp_sum word1:word0 = 0x00000001_00000000, carry=0, ovf=0, id=0.
  - Timing: rsp_valid exactly 3 cycles after the handshake.
- 128-bit subtract with borrow:
  - Stimulus: req1 nwords=3, sub=1, a=0, b=1.
  - Response: all four words 0xFFFFFFFF, carry=0, ovf=0, id=1.
- Overflow:
  - Stimulus: nwords=0, a=0x7FFFFFFF, b=1, add.
  - Response: sum=0x80000000, ovf=1, carry=0, words 1..3 = 0.
- Arbitration:
  - Stimulus: both requesters valid continuously for 4 operations; rsp_ready=1.
  - Response: rsp_id sequence 0,1,0,1; each requester's ready pulses exactly once per accepted operation.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles in DONE.
  - Response: rsp_* stable, busy=1, no req ready; one cycle after rsp_ready=1, rsp_valid=0 and the next grant is possible.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 during word 2 of a 4-word add.
  - Response: immediately busy=0, rsp_valid=0, rsp_sum=0; after release, req0 wins a simultaneous request.
